// File: rtl/voice_scheduler.sv
// Voice allocator for an 8-voice sine synth: maps note-on/off events to voices,
// fetches frequency words from a synchronous note ROM and writes the voice frequency file.
module voice_scheduler #(
    parameter int NVOICE = 8,
    parameter int FREQ_W = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_on,
    input  logic [6:0]        ev_note,
    output logic [6:0]        rom_addr,
    input  logic [FREQ_W-1:0] rom_data,
    output logic              freq_we,
    output logic [2:0]        freq_idx,
    output logic [FREQ_W-1:0] freq_data,
    output logic [7:0]        active,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               ev_ready_r;
    logic [6:0]         rom_addr_r;
    logic               freq_we_r;
    logic [2:0]         freq_idx_r;
    logic [FREQ_W-1:0]  freq_data_r;
    logic [NVOICE-1:0]  active_r;
    logic [7:0]         drop_cnt_r;
    logic [6:0]         notes_r [NVOICE];
    logic               on_r;
    logic [6:0]         note_r;
    logic [2:0]         sel_r;

    logic [NVOICE-1:0]  same_s;
    logic [NVOICE-1:0]  free_s;
    logic [3:0]         same_hit_s;
    logic [3:0]         free_hit_s;
    logic [2:0]         sel_s;
    logic               latch_s;
    logic               drop_s;
    logic               off_s;

    // Lowest set bit of v as {found, index}; scanning downward lets the lowest index win.
    function automatic logic [3:0] lowest_set(input logic [NVOICE-1:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            r = v[i] ? {1'b1, 3'(i)} : r;
        end
        return r;
    endfunction

    // Per-voice match vectors against the offered note.
    always_comb begin
        same_s = '0;
        free_s = '0;
        for (int i = 0; i < NVOICE; i++) begin
            same_s[i] = active_r[i] && (notes_r[i] == ev_note);
            free_s[i] = !active_r[i];
        end
    end

    assign same_hit_s = lowest_set(same_s);
    assign free_hit_s = lowest_set(free_s);

    // Next-state logic; the voice is chosen at acceptance so later table changes cannot move it.
    always_comb begin
        state_s = state_r;
        sel_s   = sel_r;
        latch_s = 1'b0;
        drop_s  = 1'b0;
        off_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ev_valid) begin
                    latch_s = 1'b1;
                    if (ev_on) begin
                        if (ev_note == 7'd0) begin
                            state_s = ST_IDLE;
                        end else if (same_hit_s[3]) begin
                            state_s = ST_LOOKUP;
                            sel_s   = same_hit_s[2:0];
                        end else if (free_hit_s[3]) begin
                            state_s = ST_LOOKUP;
                            sel_s   = free_hit_s[2:0];
                        end else begin
                            drop_s  = 1'b1;
                        end
                    end else begin
                        if (same_hit_s[3]) begin
                            state_s = ST_WRITE;
                            sel_s   = same_hit_s[2:0];
                            off_s   = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: state_s = ST_WAIT;
            ST_WAIT:   state_s = ST_WRITE;
            ST_WRITE:  state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register and outputs decoded from the next state so they are registered.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r    <= ST_IDLE;
            ev_ready_r <= 1'b1;
            rom_addr_r <= 7'd0;
            freq_we_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ev_ready_r <= (state_s == ST_IDLE);
            rom_addr_r <= (state_s == ST_LOOKUP) ? ev_note : 7'd0;
            freq_we_r  <= (state_s == ST_WRITE);
        end
    end

    // Event latch.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            on_r   <= 1'b0;
            note_r <= 7'd0;
            sel_r  <= 3'd0;
        end else if (latch_s) begin
            on_r   <= ev_on;
            note_r <= ev_note;
            sel_r  <= sel_s;
        end
    end

    // Write-port payload: ROM word captured leaving WAIT, zero for a matched note-off.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            freq_idx_r  <= 3'd0;
            freq_data_r <= '0;
        end else if (state_r == ST_WAIT) begin
            freq_idx_r  <= sel_r;
            freq_data_r <= rom_data;
        end else if (off_s) begin
            freq_idx_r  <= sel_s;
            freq_data_r <= '0;
        end
    end

    // Voice table commits on the edge that ends WRITE.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            active_r <= '0;
            for (int i = 0; i < NVOICE; i++) begin
                notes_r[i] <= 7'd0;
            end
        end else if (state_r == ST_WRITE) begin
            if (on_r) begin
                active_r[sel_r] <= 1'b1;
                notes_r[sel_r]  <= note_r;
            end else begin
                active_r[sel_r] <= 1'b0;
            end
        end
    end

    // Saturating drop counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign ev_ready  = ev_ready_r;
    assign rom_addr  = rom_addr_r;
    assign freq_we   = freq_we_r;
    assign freq_idx  = freq_idx_r;
    assign freq_data = freq_data_r;
    assign active    = active_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a behavioural 1-cycle-latency note ROM.
module tb_voice_scheduler;

    logic        ACLK;
    logic        ARESETn;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_note;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic        freq_we;
    logic [2:0]  freq_idx;
    logic [15:0] freq_data;
    logic [7:0]  active;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    voice_scheduler #(.NVOICE(8), .FREQ_W(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_note(ev_note),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .freq_we(freq_we), .freq_idx(freq_idx), .freq_data(freq_data),
        .active(active), .drop_cnt(drop_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [15:0] rom_fn(input logic [6:0] a);
        return (a == 7'd60) ? 16'h0106 : (16'h1000 + {9'd0, a});
    endfunction

    always @(posedge ACLK) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic on, input logic [6:0] note);
        int n;
        n = 0;
        @(negedge ACLK);
        while (!ev_ready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        @(posedge ACLK);
        #1 ev_valid = 1'b0;
    endtask

    // lat = cycle after the accept cycle in which freq_we is expected (0 = never).
    task automatic ev(input logic on, input logic [6:0] note, input int lat,
                      input logic [2:0] idx, input logic [15:0] data);
        send(on, note);
        for (int k = 1; k <= 4; k++) begin
            @(negedge ACLK);
            chk("ev_ready", 32'(ev_ready), 32'(k > lat));
            chk("rom_addr", 32'(rom_addr), (k == 1 && lat == 3) ? 32'(note) : 32'd0);
            chk("freq_we", 32'(freq_we), 32'(k == lat));
            if (k == lat) begin
                chk("freq_idx", 32'(freq_idx), 32'(idx));
                chk("freq_data", 32'(freq_data), 32'(data));
            end
        end
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        #1;
        chk("rst_ready", 32'(ev_ready), 32'd1);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_we", 32'(freq_we), 32'd0);
        chk("rst_idx", 32'(freq_idx), 32'd0);
        chk("rst_data", 32'(freq_data), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    initial begin
        ARESETn  = 1'b1;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = 7'd0;
        #2;
        do_reset();

        // Single note-on, then retrigger of the same note.
        ev(1'b1, 7'd60, 3, 3'd0, 16'h0106);
        chk("active_one", 32'(active), 32'h01);
        ev(1'b1, 7'd60, 3, 3'd0, 16'h0106);
        chk("active_retrig", 32'(active), 32'h01);

        // Chord then release of the middle note.
        ev(1'b1, 7'd64, 3, 3'd1, 16'h1040);
        ev(1'b1, 7'd67, 3, 3'd2, 16'h1043);
        chk("active_chord", 32'(active), 32'h07);
        ev(1'b0, 7'd64, 1, 3'd1, 16'h0000);
        chk("active_off", 32'(active), 32'h05);
        chk("idx_hold", 32'(freq_idx), 32'd1);
        chk("data_hold", 32'(freq_data), 32'd0);

        // Unmatched note-off and note-on 0 are consumed silently.
        ev(1'b0, 7'd72, 0, 3'd0, 16'h0000);
        ev(1'b1, 7'd0, 0, 3'd0, 16'h0000);
        chk("active_after_nop", 32'(active), 32'h05);
        chk("drop_after_nop", 32'(drop_cnt), 32'd0);

        // Fill all voices, overflow, saturate the drop counter.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ev(1'b1, 7'(10 + i), 3, 3'(i), 16'h1000 + 16'(10 + i));
        end
        chk("active_full", 32'(active), 32'hFF);
        ev(1'b1, 7'd18, 0, 3'd0, 16'h0000);
        chk("drop_one", 32'(drop_cnt), 32'd1);
        chk("active_still_full", 32'(active), 32'hFF);
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 7'(30 + (i % 50)));
        end
        @(negedge ACLK);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Freed voice 3 is reused as the lowest inactive voice.
        ev(1'b0, 7'd13, 1, 3'd3, 16'h0000);
        chk("active_hole", 32'(active), 32'hF7);
        ev(1'b1, 7'd20, 3, 3'd3, 16'h1014);
        chk("active_refill", 32'(active), 32'hFF);

        // Reset during WAIT abandons the retrigger.
        send(1'b1, 7'd20);
        @(negedge ACLK);
        @(posedge ACLK);
        #2 ARESETn = 1'b0;
        #1;
        chk("midrst_we", 32'(freq_we), 32'd0);
        chk("midrst_active", 32'(active), 32'd0);
        chk("midrst_drop", 32'(drop_cnt), 32'd0);
        chk("midrst_ready", 32'(ev_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("midrst_no_we", 32'(freq_we), 32'd0);
        end
        ARESETn = 1'b1;
        ev(1'b1, 7'd60, 3, 3'd0, 16'h0106);
        chk("active_after_rst", 32'(active), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
